dma_chunk_scheduler: RTL and testbench

- Group-level DMA frontend scheduler. Accepts one DMA job (src, dst, num_bytes) and splits it into chunks aligned to the TCDM interleaving region of each DMA backend.
- Dispatches each chunk to the backend that owns its destination region.
- Tracks outstanding chunks per backend and signals job completion once every chunk has finished.
- Sits between the group DMA frontend registers and the NumDmasPerGroup DMA backends.

---
 rtl/dma_chunk_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dma_chunk_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_chunk_scheduler.sv
// Splits one DMA job into chunks aligned to each backend's region and dispatches them in address order.
// Latency: first chunk valid the cycle after job acceptance; done_o the cycle after the last counter drains.
// Backpressure: a chunk holds valid/payload until its backend is ready; a backend at its in-flight limit stalls issue.
module dma_chunk_scheduler #(
    parameter int NumBackends    = 4,
    parameter int AddrWidth      = 32,
    parameter int ChunkBytes     = 1024,
    parameter int MaxOutstanding = 2,
    parameter int LenWidth       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [AddrWidth-1:0]   job_src_i,
    input  logic [AddrWidth-1:0]   job_dst_i,
    input  logic [LenWidth-1:0]    job_len_i,
    output logic [NumBackends-1:0] chunk_valid_o,
    input  logic [NumBackends-1:0] chunk_ready_i,
    output logic [AddrWidth-1:0]   chunk_src_o,
    output logic [AddrWidth-1:0]   chunk_dst_o,
    output logic [LenWidth-1:0]    chunk_len_o,
    input  logic [NumBackends-1:0] chunk_done_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);
    localparam int OffW  = $clog2(ChunkBytes);
    localparam int SelW  = (NumBackends > 1) ? $clog2(NumBackends) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    // One spare bit so the room-to-boundary subtraction never overflows.
    localparam int MathW = ((AddrWidth > LenWidth) ? AddrWidth : LenWidth) + 1;

    typedef enum logic [1:0] {IDLE, SPLIT, DRAIN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [AddrWidth-1:0]   cur_src, cur_dst;
    logic [LenWidth-1:0]    remaining;
    logic [CntW-1:0]        outstanding     [NumBackends];
    logic [CntW-1:0]        outstanding_nxt [NumBackends];
    logic                   err;
    logic                   err_set;
    logic                   all_idle_nxt;
    logic [SelW-1:0]        sel;
    logic [MathW-1:0]       offset, room;
    logic [LenWidth-1:0]    chunk_len;
    logic                   can_issue;
    logic                   handshake;

    generate
        if (NumBackends == 1) begin : g_sel_single
            assign sel = '0;
        end else begin : g_sel_multi
            assign sel = cur_dst[OffW +: SelW];
        end
    endgenerate

    // Chunk ends at the next region boundary or at the end of the job, whichever comes first.
    assign offset    = MathW'(cur_dst & AddrWidth'(ChunkBytes - 1));
    assign room      = MathW'(ChunkBytes) - offset;
    assign chunk_len = (MathW'(remaining) < room) ? remaining : LenWidth'(room);

    assign can_issue     = (state == SPLIT) && (outstanding[sel] < CntW'(MaxOutstanding));
    assign chunk_valid_o = can_issue ? (NumBackends'(1) << sel) : '0;
    assign handshake     = can_issue && chunk_ready_i[sel];
    assign chunk_src_o   = cur_src;
    assign chunk_dst_o   = cur_dst;
    assign chunk_len_o   = chunk_len;
    assign err_o         = err;

    // Per-backend in-flight accounting; a completion with nothing in flight is flagged instead of underflowing.
    always_comb begin
        err_set      = 1'b0;
        all_idle_nxt = 1'b1;
        for (int b = 0; b < NumBackends; b++) begin
            outstanding_nxt[b] = outstanding[b];
            if (chunk_valid_o[b] && chunk_ready_i[b] && !chunk_done_i[b]) begin
                outstanding_nxt[b] = outstanding[b] + CntW'(1);
            end else if (chunk_done_i[b] && !(chunk_valid_o[b] && chunk_ready_i[b])) begin
                if (outstanding[b] == '0) begin
                    err_set = 1'b1;
                end else begin
                    outstanding_nxt[b] = outstanding[b] - CntW'(1);
                end
            end
            if (outstanding_nxt[b] != '0) begin
                all_idle_nxt = 1'b0;
            end
        end
    end

    // Job state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; DRAIN looks at post-update counters so a same-cycle done counts.
    always_comb begin
        state_nxt   = state;
        job_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (state)
            IDLE: begin
                job_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (job_valid_i) begin
                    state_nxt = (job_len_i == '0) ? DONE : SPLIT;
                end
            end
            SPLIT: begin
                if (handshake && (remaining == chunk_len)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (all_idle_nxt) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job cursor, counters and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            err       <= 1'b0;
            for (int b = 0; b < NumBackends; b++) begin
                outstanding[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NumBackends; b++) begin
                outstanding[b] <= outstanding_nxt[b];
            end
            if (err_set) begin
                err <= 1'b1;
            end
            if ((state == IDLE) && job_valid_i) begin
                cur_src   <= job_src_i;
                cur_dst   <= job_dst_i;
                remaining <= job_len_i;
            end else if (handshake) begin
                cur_src   <= cur_src + AddrWidth'(chunk_len);
                cur_dst   <= cur_dst + AddrWidth'(chunk_len);
                remaining <= remaining - chunk_len;
            end
        end
    end
endmodule

// File: tb/tb_dma_chunk_scheduler.sv
// Bench for dma_chunk_scheduler: directed jobs plus randomized jobs, backpressure and completions.
// Every cycle the outputs are compared against a job-level model built from chunk lists.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_dma_chunk_scheduler;
    localparam int NB = 4;
    localparam int AW = 32;
    localparam int CB = 1024;
    localparam int MO = 2;
    localparam int LW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          job_valid_i;
    logic          job_ready_o;
    logic [AW-1:0] job_src_i, job_dst_i;
    logic [LW-1:0] job_len_i;
    logic [NB-1:0] chunk_valid_o, chunk_ready_i, chunk_done_i;
    logic [AW-1:0] chunk_src_o, chunk_dst_o;
    logic [LW-1:0] chunk_len_o;
    logic          busy_o, done_o, err_o;

    dma_chunk_scheduler #(
        .NumBackends(NB), .AddrWidth(AW), .ChunkBytes(CB), .MaxOutstanding(MO), .LenWidth(LW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_src_i(job_src_i), .job_dst_i(job_dst_i), .job_len_i(job_len_i),
        .chunk_valid_o(chunk_valid_o), .chunk_ready_i(chunk_ready_i),
        .chunk_src_o(chunk_src_o), .chunk_dst_o(chunk_dst_o), .chunk_len_o(chunk_len_o),
        .chunk_done_i(chunk_done_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          be;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } chunk_t;

    // Reference model: pending chunk list of the current job, in-flight count per backend,
    // job phase (0 idle, 1 issuing, 2 waiting for completions, 3 completion cycle).
    chunk_t q[$];
    chunk_t obs[$];
    int     mout[NB];
    int     ph;
    logic   err_m;
    int     n_chk = 0;
    int     n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void plan(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        chunk_t      c;
        logic [31:0] room, n;
        q.delete();
        while (l != 0) begin
            room  = CB - (d % CB);
            n     = (l < room) ? l : room;
            c.be  = int'((d / CB) % NB);
            c.src = s;
            c.dst = d;
            c.len = n;
            q.push_back(c);
            s = s + n;
            d = d + n;
            l = l - n;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        for (int b = 0; b < NB; b++) mout[b] = 0;
        ph    = 0;
        err_m = 1'b0;
    endfunction

    // One clock: check outputs against the model, apply inputs, advance the model.
    task automatic cycle(input logic jv, input logic [31:0] js, input logic [31:0] jd,
                         input logic [31:0] jl, input logic [NB-1:0] rdy,
                         input logic [NB-1:0] dn, input logic r);
        logic [NB-1:0] ev, hs;
        bit            all0;
        chunk_t        c;
        ev = '0;
        if (ph == 1 && q.size() > 0 && mout[q[0].be] < MO) ev[q[0].be] = 1'b1;
        check("job_ready", job_ready_o, ph == 0);
        check("busy", busy_o, ph != 0);
        check("done", done_o, ph == 3);
        check("err", err_o, err_m);
        check("chunk_valid", chunk_valid_o, ev);
        if (ev != 0) begin
            check("chunk_src", chunk_src_o, q[0].src);
            check("chunk_dst", chunk_dst_o, q[0].dst);
            check("chunk_len", chunk_len_o, q[0].len);
        end
        if ((chunk_valid_o & rdy) != 0 && !r) begin
            c.be = -1;
            for (int b = 0; b < NB; b++) if (chunk_valid_o[b]) c.be = b;
            c.src = chunk_src_o;
            c.dst = chunk_dst_o;
            c.len = chunk_len_o;
            obs.push_back(c);
        end
        rst_i         = r;
        job_valid_i   = jv;
        job_src_i     = js;
        job_dst_i     = jd;
        job_len_i     = jl;
        chunk_ready_i = rdy;
        chunk_done_i  = dn;
        if (r) begin
            model_reset();
        end else begin
            hs = ev & rdy;
            for (int b = 0; b < NB; b++) begin
                if (hs[b] && !dn[b]) mout[b]++;
                else if (dn[b] && !hs[b]) begin
                    if (mout[b] == 0) err_m = 1'b1;
                    else mout[b]--;
                end
            end
            all0 = 1'b1;
            for (int b = 0; b < NB; b++) if (mout[b] != 0) all0 = 1'b0;
            case (ph)
                0: if (jv) begin
                    plan(js, jd, jl);
                    ph = (q.size() == 0) ? 3 : 1;
                end
                1: if (hs != 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0) ph = 2;
                end
                2: if (all0) ph = 3;
                default: ph = 0;
            endcase
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, '0, '0, 1'b0);
    endtask

    // mode 0: random; 1: hold backend0 completions until chunk at 0x2000 has stalled;
    // 2: deny backend1 ready for 5 cycles on chunk 0x400; 3: reset in the middle of issuing.
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input int rp, input int dp, input int mode);
        logic [NB-1:0] rdy, dn;
        logic          jv;
        int            n, stall, nsplit;
        bit            released;
        obs.delete();
        stall    = 0;
        nsplit   = 0;
        released = 1'b0;
        for (int b = 0; b < NB; b++) rdy[b] = ($urandom_range(99) < rp);
        cycle(1'b1, s, d, l, rdy, '0, 1'b0);
        n = 0;
        while (ph != 0) begin
            n++;
            if (n > 3000) begin
                check("job_timeout", ph, 0);
                break;
            end
            for (int b = 0; b < NB; b++) begin
                rdy[b] = ($urandom_range(99) < rp);
                dn[b]  = (mout[b] > 0) && ($urandom_range(99) < dp);
            end
            if (mode == 1 && !released) begin
                dn[0] = 1'b0;
                if (q.size() > 0 && q[0].dst == 32'h2000 && mout[0] == MO) begin
                    stall++;
                    if (stall > 3) begin
                        dn[0]    = 1'b1;
                        released = 1'b1;
                    end
                end
            end
            if (mode == 2 && q.size() > 0 && q[0].dst == 32'h400 && stall < 5) begin
                rdy[1] = 1'b0;
                stall++;
            end
            if (mode == 3) begin
                if (ph == 1) nsplit++;
                if (nsplit == 3) begin
                    cycle(1'b0, 0, 0, 0, rdy, dn, 1'b1);
                    break;
                end
            end
            jv = ($urandom_range(3) == 0);
            cycle(jv, $urandom, $urandom, $urandom_range(8192), rdy, dn, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] s, d, l;
        logic [31:0] u_dst [3];
        logic [31:0] u_src [3];
        logic [31:0] u_len [3];
        u_dst = '{32'h300, 32'h400, 32'h800};
        u_src = '{32'h10, 32'h110, 32'h510};
        u_len = '{32'h100, 32'h400, 32'h100};

        rst_i = 1'b1; job_valid_i = 1'b0; job_src_i = '0; job_dst_i = '0; job_len_i = '0;
        chunk_ready_i = '0; chunk_done_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        idle(2);

        // Completion on an idle backend is an error and stays flagged.
        cycle(1'b0, 0, 0, 0, '0, 4'b1000, 1'b0);
        idle(3);

        // Aligned job.
        run_job(32'h8000_0000, 32'h0, 32'h1000, 100, 50, 0);
        check("aln_count", obs.size(), 4);
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            check("aln_be", obs[i].be, i);
            check("aln_dst", obs[i].dst, 32'h400 * i);
            check("aln_src", obs[i].src, 32'h8000_0000 + 32'h400 * i);
            check("aln_len", obs[i].len, 32'h400);
        end
        idle(2);

        // Unaligned job.
        run_job(32'h10, 32'h300, 32'h600, 100, 40, 0);
        check("unal_count", obs.size(), 3);
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            check("unal_be", obs[i].be, i);
            check("unal_dst", obs[i].dst, u_dst[i]);
            check("unal_src", obs[i].src, u_src[i]);
            check("unal_len", obs[i].len, u_len[i]);
        end

        // Zero-length job.
        run_job(32'h1234, 32'h5678, 32'h0, 100, 50, 0);
        check("zero_count", obs.size(), 0);

        // In-flight limit on backend0.
        run_job(32'h0, 32'h0, 32'h3000, 100, 30, 1);
        check("lim_count", obs.size(), 12);
        if (obs.size() > 8) check("lim_chunk8_dst", obs[8].dst, 32'h2000);

        // Backpressure on backend1.
        run_job(32'h4000, 32'h0, 32'h1000, 100, 50, 2);
        check("bp_count", obs.size(), 4);

        // Reset in the middle of a job clears the sticky error and the counters.
        run_job(32'h0, 32'h0, 32'h3000, 60, 20, 3);
        idle(2);
        cycle(1'b0, 0, 0, 0, '0, 4'b0001, 1'b0);
        idle(1);
        cycle(1'b0, 0, 0, 0, '0, '0, 1'b1);
        idle(1);

        // Random jobs, some wrapping past the top of the address space.
        for (int j = 0; j < 40; j++) begin
            s = $urandom;
            d = ($urandom_range(3) == 0) ? (32'hFFFF_F000 + $urandom_range(4095)) : $urandom;
            l = ($urandom_range(7) == 0) ? 32'h0 : $urandom_range(1, 6000);
            run_job(s, d, l, $urandom_range(30, 100), $urandom_range(10, 70), 0);
            idle($urandom_range(2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
